// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver state type, line levels and parity helper.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} t_uart_rx_state;

    localparam logic IDLE_VAL  = 1'b1;
    localparam logic START_VAL = 1'b0;

    // Expected parity bit for up to 9 data bits; narrower words are zero-extended,
    // which leaves the XOR unchanged.
    function automatic logic parity_calc(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: divides clk by CLK_DIV into a one-cycle tick, held at phase 0 by clr.
// Ports: clk, rst (async, active-high), clr (sync clear/hold), tick (pulse every CLK_DIV clk).
module uart_baud_tick #(
    parameter int CLK_DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int W = $clog2(CLK_DIV);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    assign tick = !clr && cnt == LAST;

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else cnt <= (clr || tick) ? '0 : cnt + 1'b1;

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with mid-bit sampling, stop/parity check and valid/ready holding register.
// Ports: clk, rst (async, active-high), rx (serial line, idle 1), rx_en (gates start detection),
//        rx_ready (consumer accept), rx_data/rx_valid (holding register), frame_err/parity_err
//        (qualify rx_data), overrun_err (1-cycle pulse, frame lost), rx_busy (FSM not idle).
// Optional parity bit and check are built only when UART_RX_PARITY_EN is defined.
module uart_rx_os #(
    parameter int DATA_BITS  = 8,
    parameter int CLK_DIV    = 27,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rx_en,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 rx_busy
);

    import uart_pkg::*;

    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] MID_START = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] MID_BIT   = SW'(OVERSAMPLE - 1);
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    t_uart_rx_state state, state_n;
    logic rx_meta, rx_s, clr, tick, mid, done, load, ferr, ferr_n, wait_idle;
    logic [SW-1:0] scnt;
    logic [3:0] bcnt;
    logic [DATA_BITS-1:0] shreg;

    assign clr = state == IDLE;

    uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    // START samples half a bit in; afterwards every full bit lands mid-bit.
    assign mid     = tick && scnt == ((state == START) ? MID_START : MID_BIT);
    assign ferr_n  = ferr || rx_s == START_VAL;
    assign load    = done && (!rx_valid || rx_ready);
    assign rx_busy = state != IDLE;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        done    = 1'b0;
        case (state)
            IDLE:   if (rx_en && rx_s == START_VAL && !wait_idle) state_n = START;
            START:  if (mid) state_n = (rx_s == IDLE_VAL) ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:   if (mid && bcnt == LAST_DATA) state_n = PARITY;
            PARITY: if (mid) state_n = STOP;
`else
            DATA:   if (mid && bcnt == LAST_DATA) state_n = STOP;
`endif
            STOP:   if (mid && bcnt == LAST_STOP) begin
                state_n = IDLE;
                done    = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta     <= IDLE_VAL;
            rx_s        <= IDLE_VAL;
            scnt        <= '0;
            bcnt        <= '0;
            shreg       <= '0;
            ferr        <= 1'b0;
            wait_idle   <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            if (state == IDLE || mid) scnt <= '0;
            else if (tick) scnt <= scnt + 1'b1;
            // A state change at a mid-bit point always means the bit count is complete.
            if (state == IDLE || state == START) bcnt <= '0;
            else if (mid) bcnt <= (state_n != state) ? '0 : bcnt + 1'b1;
            if (state == DATA && mid) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (state == START) ferr <= 1'b0;
            else if (state == STOP && mid && rx_s == START_VAL) ferr <= 1'b1;
            // A frame ending on a low line (break) must see the line idle again before re-arming.
            if (done) wait_idle <= rx_s == START_VAL;
            else if (rx_s == IDLE_VAL) wait_idle <= 1'b0;
            rx_valid <= load || (rx_valid && !rx_ready);
            if (load) begin
                rx_data   <= shreg;
                frame_err <= ferr_n;
            end
            overrun_err <= done && rx_valid && !rx_ready;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic perr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perr       <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (state == PARITY && mid)
                perr <= rx_s != parity_calc(9'(shreg), PARITY_ODD[0]);
            if (load) parity_err <= perr;
        end
    end
`else
    logic unused_parity_odd;

    assign unused_parity_odd = PARITY_ODD[0];
    assign parity_err        = 1'b0;
`endif

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Parametrised, oversampling UART receiver. Next generation of the team's fixed 8-bit, one-sample-per-clock receiver.
- Adds configurable data width, an internal baud divider, mid-bit sampling, stop-bit checking and optional parity.
- Adds a valid/ready output holding register with overrun detection.
- Sits between the pad-side rx line and a byte-stream consumer (FIFO or bus bridge).

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, LSB first.
CLK_DIV, 27, clk cycles per oversample tick, >=2.
OVERSAMPLE, 16, ticks per bit, even, >=4.
STOP_BITS, 1, stop bits checked, 1 or 2.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored unless the parity macro is defined.

Ports:
clk  input  1  clock.
rst  input  1  reset, asynchronous, active-high.
rx  input  1  asynchronous serial line; idle = 1.
rx_en  input  1  gates start-bit detection only.
rx_ready  input  1  consumer accepts rx_data.
rx_data  output  DATA_BITS  received word (holding register).
rx_valid  output  1  rx_data valid; held until accepted.
frame_err  output  1  qualifies rx_data: a stop bit sampled 0.
parity_err  output  1  qualifies rx_data: parity mismatch.
overrun_err  output  1  single-cycle pulse: frame lost.
rx_busy  output  1  state != IDLE.

Behaviour:
- Reset values: rx_data 0, rx_valid 0, frame_err 0, parity_err 0, overrun_err 0, rx_busy 0. The synchroniser resets to 1.
- rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s.
- Tick counter: counts 0..CLK_DIV-1 and asserts tick at CLK_DIV-1.
  - Held at 0 in IDLE, so the bit phase aligns to the start edge.
  - Bit time = CLK_DIV*OVERSAMPLE clk.
- Sample counter scnt: 0..OVERSAMPLE-1, advances on tick. The mid-bit point is the tick where scnt==OVERSAMPLE/2-1 in START, and scnt==OVERSAMPLE-1 in the remaining states.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rx_en && rx_s==0 -> START, counters cleared.
  - START: at the mid-bit point, rx_s==0 -> DATA with scnt=0. rx_s==1 -> IDLE (false start: no flags, no output).
  - DATA: samples rx_s once per bit and shifts it into the shift register LSB-first. After DATA_BITS samples -> PARITY (macro defined) or STOP.
  - PARITY: samples one bit and compares it with the XOR of the data bits (inverted if PARITY_ODD) -> STOP.
  - STOP: samples STOP_BITS bits; any 0 sets the frame-error latch.
    - After the last stop sample -> IDLE in the same cycle. This is at mid stop bit, so back-to-back frames resync.
- Frame completion, at the cycle of the last stop sample:
  - Holding register empty, or being accepted this cycle (rx_valid && rx_ready): load rx_data, frame_err and parity_err; rx_valid=1 on the next edge.
  - Holding register full and not accepted: frame discarded, overrun_err pulses 1 cycle, held data and flags unchanged.
- Handshake:
  - rx_valid falls the cycle after rx_valid && rx_ready, unless a new frame loads in the same cycle, in which case rx_valid stays 1.
  - rx_data and flags stable while rx_valid && !rx_ready.
- rx_en deassertion mid-frame: the frame completes normally; only new start detection is blocked.
- Reset mid-frame: immediate return to IDLE, all outputs to reset values, partial frame discarded.
- Break (rx held 0): yields a frame with frame_err=1, then the FSM waits in IDLE until rx_s returns to 1 before accepting a new start.

Optional Feature:
UART_RX_PARITY_EN
- Defined: PARITY state and parity check present; parity_err is driven.
- Undefined: no parity bit is expected, DATA goes directly to STOP, and parity_err is tied 0. The port list is unchanged.

Decomposition:
- Package uart_pkg:
  - state enum t_uart_rx_state {IDLE, START, DATA, PARITY, STOP}.
  - Localparams IDLE_VAL=1'b1 and START_VAL=1'b0.
  - Function parity_calc(data, odd).
- One sub-module, uart_baud_tick: CLK_DIV tick generator with a synchronous clear input. It is reusable by the matching transmitter.

Test Plan:
All tests use CLK_DIV=4, OVERSAMPLE=16, i.e. 64 clk per bit.
- Test 1, normal 8N1 frame: drive 0xA5, rx_ready=1 -> rx_valid for 1 cycle about 9.5 bit times (~610 clk) after the falling edge; rx_data=0xA5, frame_err=0.
- Test 2, short glitch: rx low for 20 clk (under half a bit) -> FSM returns to IDLE; rx_valid, frame_err and overrun_err stay 0.
- Test 3, bad stop bit: 0x3C with stop bit driven 0 -> rx_valid=1, rx_data=0x3C, frame_err=1. The following idle line plus a 0x5A frame gives frame_err=0.
- Test 4, overrun: rx_ready=0, frames 0x11 then 0x22 -> overrun_err pulses 1 cycle at the end of the second frame; rx_data stays 0x11. Raising rx_ready -> rx_valid drops the next cycle.
- Test 5, parity (macro defined, PARITY_ODD=0): 0x07 with parity bit 1 -> parity_err=0; 0x07 with parity bit 0 -> parity_err=1.
- Test 6, reset mid-frame: rst asserted in DATA after 3 bits -> all outputs 0 and rx_busy 0 immediately. A following full 0xC3 frame is received correctly.
